// File: rtl/mdsp_pkg.sv
// rtl/mdsp_pkg.sv - shared mdsp core constants and sample type
package mdsp_pkg;

  // Native sample width of the mdsp datapath (x_i / x_o).
  localparam int c_mdsp_data_width = 24;

  typedef logic signed [c_mdsp_data_width-1:0] mdsp_sample_t;

endpackage

// File: rtl/mdsp_x_feeder_if.sv
// rtl/mdsp_x_feeder_if.sv - sample input stream and mdsp pull handshake bundle
//
// s_valid_i / s_data_i : free-running sample strobe and signed sample from acquisition
// x_req_i              : sample request from the mdsp core
// x_valid_o / x_o      : registered response strobe and signed sample to the core
// master modport: environment side (acquisition + core); slave modport: feeder.
interface mdsp_x_feeder_if
  import mdsp_pkg::*;
#(
  parameter int g_data_width = c_mdsp_data_width,
  parameter int g_in_width   = 16
) ();

  logic                           s_valid_i;
  logic signed [g_in_width-1:0]   s_data_i;
  logic                           x_req_i;
  logic                           x_valid_o;
  logic signed [g_data_width-1:0] x_o;

  modport master (
    output s_valid_i, s_data_i, x_req_i,
    input  x_valid_o, x_o
  );

  modport slave (
    input  s_valid_i, s_data_i, x_req_i,
    output x_valid_o, x_o
  );

endinterface

// File: rtl/mdsp_sync_fifo.sv
// rtl/mdsp_sync_fifo.sv - generic single-clock FIFO with registered read port
//
// clk, rst : clock, synchronous active-high reset
// push     : write request; accepted when not full, or when full with an accepted pop
// wr_data  : data written on an accepted push
// pop      : read request; accepted when not empty
// rd_data  : registered read port; loads the head on an accepted pop, else holds
// full, empty, count : occupancy status (count is 0..g_depth)
module mdsp_sync_fifo #(
  parameter int g_width = 24,
  parameter int g_depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [g_width-1:0]       wr_data,
  input  logic                     pop,
  output logic [g_width-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(g_depth):0] count
);

  localparam int c_aw = $clog2(g_depth);

  logic [g_width-1:0] mem [g_depth];
  logic [c_aw:0]      wr_ptr;
  logic [c_aw:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[c_aw] != rd_ptr[c_aw]) &&
                 (wr_ptr[c_aw-1:0] == rd_ptr[c_aw-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign pop_ok  = pop && !empty;
  // When full, the simultaneous pop frees the head slot, which is exactly the
  // slot being written; the read below still sees the old head value.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr[c_aw-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (c_aw+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + (c_aw+1)'(1);
        rd_data <= mem[rd_ptr[c_aw-1:0]];
      end
    end
  end

endmodule

// File: rtl/mdsp_x_feeder.sv
// rtl/mdsp_x_feeder.sv - buffered sample feeder for the mdsp core x input
//
// clk_i, rst_i : clock, synchronous active-high reset
// bus          : sample stream in, x_req/x_valid/x pull handshake out (slave side)
// clr_i        : clears both event counters and both sticky flags
// level_o      : FIFO occupancy
// ovf_cnt_o    : saturating count of samples dropped on a full FIFO
// unf_cnt_o    : saturating count of requests served from the hold value
// ovf_o, unf_o : sticky overflow / underrun flags
module mdsp_x_feeder
  import mdsp_pkg::*;
#(
  parameter int g_data_width = c_mdsp_data_width,
  parameter int g_in_width   = 16,
  parameter int g_fifo_depth = 16,
  parameter int g_cnt_width  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  mdsp_x_feeder_if.slave                bus,
  input  logic                          clr_i,
  output logic [$clog2(g_fifo_depth):0] level_o,
  output logic [g_cnt_width-1:0]        ovf_cnt_o,
  output logic [g_cnt_width-1:0]        unf_cnt_o,
  output logic                          ovf_o,
  output logic                          unf_o
);

  logic [g_data_width-1:0] wr_sample;
  logic [g_data_width-1:0] hold_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    ovf_evt;
  logic                    unf_evt;

  assign wr_sample = g_data_width'($signed(bus.s_data_i));

  // The FIFO's registered read port doubles as the hold register: it only
  // changes on a real pop, so an underrun re-presents the last sample.
  mdsp_sync_fifo #(
    .g_width (g_data_width),
    .g_depth (g_fifo_depth)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (bus.s_valid_i),
    .wr_data (wr_sample),
    .pop     (bus.x_req_i),
    .rd_data (hold_q),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (level_o)
  );

  assign bus.x_o = hold_q;

  // A full FIFO is never empty, so a request in the same cycle always pops
  // and makes room; only a write without a request is dropped.
  assign ovf_evt = bus.s_valid_i && fifo_full && !bus.x_req_i;
  // Empty is the pre-write state: a same-cycle write does not bypass.
  assign unf_evt = bus.x_req_i && fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.x_valid_o <= 1'b0;
    end else begin
      bus.x_valid_o <= bus.x_req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      ovf_cnt_o <= '0;
      unf_cnt_o <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf_o <= 1'b1;
        if (ovf_cnt_o != '1) begin
          ovf_cnt_o <= ovf_cnt_o + g_cnt_width'(1);
        end
      end
      if (unf_evt) begin
        unf_o <= 1'b1;
        if (unf_cnt_o != '1) begin
          unf_cnt_o <= unf_cnt_o + g_cnt_width'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mdsp_x_feeder.sv
// tb/tb_mdsp_x_feeder.sv - self-checking bench for mdsp_x_feeder
module tb_mdsp_x_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [4:0]  level;
  logic [15:0] ovf_cnt;
  logic [15:0] unf_cnt;
  logic        ovf;
  logic        unf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdsp_x_feeder_if #(.g_data_width(24), .g_in_width(16)) bus ();

  mdsp_x_feeder #(
    .g_data_width (24),
    .g_in_width   (16),
    .g_fifo_depth (16),
    .g_cnt_width  (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .clr_i     (clr),
    .level_o   (level),
    .ovf_cnt_o (ovf_cnt),
    .unf_cnt_o (unf_cnt),
    .ovf_o     (ovf),
    .unf_o     (unf)
  );

  typedef struct {
    logic s_valid;
    int   s_data;
    logic x_req;
    logic exp_valid;
    int   exp_x;
    int   exp_level;
    int   exp_unf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input logic r);
    bus.s_valid_i = v;
    bus.s_data_i  = 16'(d);
    bus.x_req_i   = r;
  endtask

  initial begin
    vecs[0] = '{1'b1,    100, 1'b0, 1'b0,    0, 1, 0};
    vecs[1] = '{1'b1,   -100, 1'b0, 1'b0,    0, 2, 0};
    vecs[2] = '{1'b1,  32767, 1'b0, 1'b0,    0, 3, 0};
    vecs[3] = '{1'b0,      0, 1'b1, 1'b1,  100, 2, 0};
    vecs[4] = '{1'b0,      0, 1'b0, 1'b0,  100, 2, 0};
    vecs[5] = '{1'b0,      0, 1'b1, 1'b1, -100, 1, 0};
    vecs[6] = '{1'b0,      0, 1'b1, 1'b1, 32767, 0, 0};
    vecs[7] = '{1'b0,      0, 1'b0, 1'b0, 32767, 0, 0};

    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    tick();
    chk("rst_x_valid", int'(bus.x_valid_o), 0);
    chk("rst_x", int'(bus.x_o), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf_cnt", int'(ovf_cnt), 0);
    chk("rst_unf_cnt", int'(unf_cnt), 0);
    chk("rst_flags", int'({ovf, unf}), 0);
    rst = 1'b0;

    // Basic write/read sequence, table-driven.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].s_valid, vecs[i].s_data, vecs[i].x_req);
      tick();
      chk($sformatf("vec%0d_valid", i), int'(bus.x_valid_o), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_x", i), int'(bus.x_o), vecs[i].exp_x);
      chk($sformatf("vec%0d_level", i), int'(level), vecs[i].exp_level);
      chk($sformatf("vec%0d_unf", i), int'(unf_cnt), vecs[i].exp_unf);
    end

    // Overfill: 20 writes into 16 entries.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
    end
    chk("ovf_level", int'(level), 16);
    chk("ovf_cnt", int'(ovf_cnt), 4);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_unf_flag", int'(unf), 0);
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain%0d_valid", i), int'(bus.x_valid_o), 1);
      chk($sformatf("drain%0d_x", i), int'(bus.x_o), i);
    end
    drive(1'b0, 0, 1'b0);
    tick();
    chk("drain_end_valid", int'(bus.x_valid_o), 0);
    chk("drain_end_level", int'(level), 0);

    // Underrun repeats the last sample.
    drive(1'b1, -5, 1'b0);
    tick();
    drive(1'b0, 0, 1'b1);
    tick();
    chk("m5_x", int'(bus.x_o), -5);
    chk("m5_unf", int'(unf_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("unf%0d_valid", i), int'(bus.x_valid_o), 1);
      chk($sformatf("unf%0d_x", i), int'(bus.x_o), -5);
    end
    drive(1'b0, 0, 1'b0);
    tick();
    chk("unf_cnt3", int'(unf_cnt), 3);
    chk("unf_flag", int'(unf), 1);

    // Write into empty FIFO with a same-cycle request: no bypass.
    drive(1'b1, 7, 1'b1);
    tick();
    chk("nobyp_valid", int'(bus.x_valid_o), 1);
    chk("nobyp_x", int'(bus.x_o), -5);
    chk("nobyp_unf", int'(unf_cnt), 4);
    chk("nobyp_level", int'(level), 1);
    drive(1'b0, 0, 1'b1);
    tick();
    chk("nobyp_next_x", int'(bus.x_o), 7);
    chk("nobyp_next_unf", int'(unf_cnt), 4);
    chk("nobyp_next_level", int'(level), 0);

    // Full FIFO: write plus request in the same cycle is accepted.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 100 + i, 1'b0);
      tick();
    end
    chk("full_level", int'(level), 16);
    chk("full_ovf_cnt", int'(ovf_cnt), 4);
    drive(1'b1, 555, 1'b1);
    tick();
    chk("fullrw_valid", int'(bus.x_valid_o), 1);
    chk("fullrw_x", int'(bus.x_o), 100);
    chk("fullrw_level", int'(level), 16);
    chk("fullrw_ovf_cnt", int'(ovf_cnt), 4);

    // Clear wins over a same-cycle overflow event.
    drive(1'b1, 1, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf_cnt", int'(ovf_cnt), 0);
    chk("clr_unf_cnt", int'(unf_cnt), 0);
    chk("clr_flags", int'({ovf, unf}), 0);
    chk("clr_level", int'(level), 16);

    // Saturation of the overflow counter.
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    chk("sat_ovf_cnt", int'(ovf_cnt), 65535);
    chk("sat_ovf_flag", int'(ovf), 1);
    tick();
    chk("sat_hold_ovf_cnt", int'(ovf_cnt), 65535);

    // Drain to level 5 (contents 101..115, 555), then reset mid-stream.
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick();
    end
    chk("pre_rst_level", int'(level), 5);
    chk("pre_rst_x", int'(bus.x_o), 111);
    rst = 1'b1;
    tick();
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_x", int'(bus.x_o), 0);
    chk("mid_rst_valid", int'(bus.x_valid_o), 0);
    chk("mid_rst_ovf_cnt", int'(ovf_cnt), 0);
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    chk("post_rst_valid", int'(bus.x_valid_o), 0);
    drive(1'b0, 0, 1'b1);
    tick();
    chk("first_req_valid", int'(bus.x_valid_o), 1);
    chk("first_req_x", int'(bus.x_o), 0);
    chk("first_req_unf", int'(unf_cnt), 1);
    drive(1'b0, 0, 1'b0);
    tick();
    chk("first_req_pulse", int'(bus.x_valid_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdsp_x_feeder.md
# mdsp_x_feeder

Input sample feeder for the `mdsp` microcoded DSP core. It buffers a free-running stream of signed samples from the acquisition side, such as an ADC or decimator, in a small synchronous FIFO. It then serves them on the core's pull handshake (`x_req` → `x_valid`/`x`). If the FIFO runs dry, the core still receives a sample: the last value is repeated and the event is counted. If the FIFO overflows, the new sample is dropped and counted.

## Interface
Parameters:
- `g_data_width`, 24: sample width; matches the mdsp `x_i` width.
- `g_in_width`, 16: width of the incoming sample. It is sign-extended to `g_data_width`. Must be ≤ `g_data_width`.
- `g_fifo_depth`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `g_cnt_width`, 16: width of the saturating event counters.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset. Synchronous and active-high (decided).
- `s_valid_i`  in  1  input sample strobe.
- `s_data_i`  in  `g_in_width`  signed input sample.
- `x_req_i`  in  1  sample request from mdsp (`x_req_o`).
- `x_valid_o`  out  1  sample-valid strobe to mdsp (`x_valid_i`).
- `x_o`  out  `g_data_width`  signed sample to mdsp (`x_i`).
- `clr_i`  in  1  clears both counters and the sticky flags.
- `level_o`  out  $clog2(`g_fifo_depth`)+1  current FIFO occupancy.
- `ovf_cnt_o`  out  `g_cnt_width`  count of dropped input samples; saturating.
- `unf_cnt_o`  out  `g_cnt_width`  count of requests served from hold; saturating.
- `ovf_o`  out  1  sticky overflow flag.
- `unf_o`  out  1  sticky underrun flag.

## Operation
- Write: `s_valid_i`=1 and FIFO not full, or full with a simultaneous read in the same cycle → sign-extend `s_data_i` and push.
- Write with FIFO full and no simultaneous read → sample dropped; `ovf_cnt_o` += 1; `ovf_o` ← 1.
- Read: `x_req_i`=1 and FIFO not empty → pop head. The popped value also loads the hold register.
- `x_req_i`=1 with FIFO empty → no pop. The hold register value is presented; `unf_cnt_o` += 1; `unf_o` ← 1.
- No bypass: a write to an empty FIFO in the same cycle as `x_req_i` is still an underrun. The written sample is stored for the next request.
- Every `x_req_i` cycle produces exactly one `x_valid_o` pulse. Back-to-back requests are served at 1 sample/cycle.
- Counters saturate at all-ones and do not wrap.
- `clr_i` zeroes both counters and both flags next cycle. An event in the same cycle as `clr_i` is lost, because clear wins. FIFO contents are unaffected by `clr_i`.
- Pointers are `$clog2(depth)`+1 bits. Full and empty are derived from the MSB and the equality of the remaining bits, so wrap-around is exact.

## Timing
- `x_req_i` high at edge N → `x_valid_o`=1 and `x_o` valid during cycle N+1. Both are registered, giving latency 1.
- `x_valid_o` is a single-cycle pulse per request. `x_o` holds its value between pulses.
- `level_o` reflects the push/pop of edge N from cycle N+1.
- Write-to-readable latency is 1: a sample pushed at edge N can be popped by a request sampled at edge N+1.
- Reset values: `x_valid_o`=0, `x_o`=0, hold register=0, `level_o`=0, both counters 0, both flags 0, pointers 0.
- Reset asserted mid-stream empties the FIFO and drops any pending response. A request in the reset cycle gets no `x_valid_o`.
- The first request after reset with nothing written returns 0 and counts one underrun.

## Structure
- Shared package `mdsp_pkg` holds:
  - `c_mdsp_data_width` = 24;
  - typedef `mdsp_sample_t` as logic signed [23:0].
- Sub-module `mdsp_sync_fifo` is a generic single-clock FIFO: push, pop, full, empty, count, and a registered read port. `mdsp_x_feeder` wraps it with the hold register, response pipeline, and counters.

## Test plan
- Reset, then write 3 samples 100, −100, 32767; issue 3 single-cycle requests → `x_valid_o` pulses 1 cycle after each request with 100, −100, 32767 (sign-extended); `level_o` goes 3→0; `unf_cnt_o`=0.
- Write 20 samples 0..19 with no requests (depth 16) → `level_o`=16; `ovf_cnt_o`=4; `ovf_o`=1. Then 16 back-to-back requests → 16 consecutive `x_valid_o` pulses with values 0..15.
- Empty FIFO after last value −5; issue 3 requests → each returns −5; `unf_cnt_o`=3; `unf_o`=1.
- FIFO full: write and request in the same cycle → write accepted; `ovf_cnt_o` unchanged; `level_o` stays 16.
- Empty FIFO: write 7 and request in the same cycle → response is the hold value and an underrun is counted. The next request returns 7.
- Force `ovf_cnt_o` to 0xFFFF via overflow, then one more overflow → stays 0xFFFF. Assert `clr_i` → counters and flags 0. Assert `rst_i` with `level_o`=5 → `level_o`=0 and `x_o`=0 next cycle.
